// File: rtl/multiport_register_file_pkg.sv
// Shared defaults and constants for the register file, decoder and writeback.
package multiport_register_file_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;
    // Architectural zero register address
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// Busy-bit scoreboard: one bit per register, two clear ports, one set port.
// Reservation beats clear. Read taps are registered and show the post-update state.
module multiport_register_file_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr0_en,
    input  logic [ADDR_W-1:0] i_clr0_addr,
    input  logic              i_clr1_en,
    input  logic [ADDR_W-1:0] i_clr1_addr,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic [ADDR_W-1:0] i_ra,
    input  logic [ADDR_W-1:0] i_rb,
    output logic              o_busyA,
    output logic              o_busyB
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             r_busyA;
    logic             r_busyB;

    // Next scoreboard: clears from both write ports first, then the reservation on top
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr0_en) w_busy_nxt[i_clr0_addr] = 1'b0;
        if (i_clr1_en) w_busy_nxt[i_clr1_addr] = 1'b0;
        if (i_set_en)  w_busy_nxt[i_set_addr]  = 1'b1;
    end

    // Scoreboard state and read taps (taps see this edge's update)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_busyA <= 1'b0;
            r_busyB <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_busyA <= w_busy_nxt[i_ra];
            r_busyB <= w_busy_nxt[i_rb];
        end
    end

    assign o_busyA = r_busyA;
    assign o_busyB = r_busyB;

endmodule

// File: rtl/multiport_register_file.sv
// Two-write / two-read register file with registered reads, optional
// write-first bypass, zero register and a busy scoreboard for decode stalls.
module multiport_register_file
    import multiport_register_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic              we0,
    input  logic [ADDR_W-1:0] rw0,
    input  logic [DATA_W-1:0] busw0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] rw1,
    input  logic [DATA_W-1:0] busw1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic              busyA,
    output logic              busyB,
    output logic              wr_conflict
);

    localparam int               DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);
    localparam logic             ZEN   = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_rf [DEPTH];
    logic [DATA_W-1:0] r_busA;
    logic [DATA_W-1:0] r_busB;
    logic              r_conflict;

    logic              w_we0;
    logic              w_we1;
    logic              w_rsv;
    logic              w_conflict;
    logic [DATA_W-1:0] w_rdA;
    logic [DATA_W-1:0] w_rdB;

    // Writes and reservations aimed at the zero register are dropped up front,
    // so they can neither store, clear busy, nor flag a conflict.
    assign w_we0      = we0    && !(ZEN && rw0 == ZADDR);
    assign w_we1      = we1    && !(ZEN && rw1 == ZADDR);
    assign w_rsv      = rsv_en && !(ZEN && rsv_addr == ZADDR);
    assign w_conflict = w_we0 && w_we1 && (rw0 == rw1);

    // Read mux A: array content, optionally overridden by same-cycle writes (port 1 first)
    always_comb begin
        w_rdA = r_rf[ra];
        if (BYPASS != 0) begin
            if (w_we1 && rw1 == ra)      w_rdA = busw1;
            else if (w_we0 && rw0 == ra) w_rdA = busw0;
        end
        if (ZEN && ra == ZADDR) w_rdA = '0;
    end

    // Read mux B: same rules as port A
    always_comb begin
        w_rdB = r_rf[rb];
        if (BYPASS != 0) begin
            if (w_we1 && rw1 == rb)      w_rdB = busw1;
            else if (w_we0 && rw0 == rb) w_rdB = busw0;
        end
        if (ZEN && rb == ZADDR) w_rdB = '0;
    end

    // Data array and output registers; port 1 is written last so it wins on a tie
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
            r_busA     <= '0;
            r_busB     <= '0;
            r_conflict <= 1'b0;
        end else begin
            if (w_we0) r_rf[rw0] <= busw0;
            if (w_we1) r_rf[rw1] <= busw1;
            r_busA     <= w_rdA;
            r_busB     <= w_rdB;
            r_conflict <= w_conflict;
        end
    end

    multiport_register_file_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_clr0_en   (w_we0),
        .i_clr0_addr (rw0),
        .i_clr1_en   (w_we1),
        .i_clr1_addr (rw1),
        .i_set_en    (w_rsv),
        .i_set_addr  (rsv_addr),
        .i_ra        (ra),
        .i_rb        (rb),
        .o_busyA     (busyA),
        .o_busyB     (busyB)
    );

    assign busA        = r_busA;
    assign busB        = r_busB;
    assign wr_conflict = r_conflict;

endmodule
